// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: commit-point exception/xret inputs, CSR access and flush/redirect outputs of trap_ctrl
`timescale 1ns/1ps
interface trap_ctrl_if;
  logic        exc;
  logic [63:0] exc_cause;
  logic [63:0] exc_val;
  logic [63:0] exc_pc;
  logic        mret;
  logic        sret;
  logic [63:0] mtvec;
  logic [63:0] stvec;
  logic [63:0] medeleg;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [63:0] csr_wr_data;
  logic [11:0] csr_rd_addr;
  logic [63:0] csr_rd_data;
  logic [1:0]  priv;
  logic        busy;
  logic        flush_all;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ack;
  modport master (
    output exc, exc_cause, exc_val, exc_pc, mret, sret, mtvec, stvec, medeleg,
           csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr, redirect_ack,
    input  csr_rd_data, priv, busy, flush_all, redirect_valid, redirect_pc
  );
  modport slave (
    input  exc, exc_cause, exc_val, exc_pc, mret, sret, mtvec, stvec, medeleg,
           csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr, redirect_ack,
    output csr_rd_data, priv, busy, flush_all, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap entry/return, privilege and trap CSR ownership, flush and fetch redirect sequencing
`timescale 1ns/1ps
module trap_ctrl #(
  parameter bit DELEG_EN   = 1'b1,
  parameter int TVEC_ALIGN = 2
) (
  input logic        clk,
  input logic        rst_n,
  trap_ctrl_if.slave t
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;
  localparam logic [63:0] TMASK = ~((64'd1 << TVEC_ALIGN) - 64'd1);
  state_t      state, nxt;
  logic [1:0]  priv, mpp;
  logic        mie, mpie, sie, spie, spp;
  logic [63:0] mepc, mcause, mtval, sepc, scause, stval, rpc;
  logic [63:0] mstatus, sstatus, epc, wd;
  logic        idle, take_exc, take_mret, take_sret, commit, to_s, wr;
  assign idle      = state == IDLE;
  assign take_exc  = idle && t.exc;
  assign take_mret = idle && !t.exc && t.mret && priv == 2'b11;
  assign take_sret = idle && !t.exc && !t.mret && t.sret && priv != 2'b00;
  assign commit    = take_exc || take_mret || take_sret;
  assign to_s      = DELEG_EN && priv != 2'b11 && t.medeleg[t.exc_cause[5:0]];
  assign wr        = idle && t.csr_wr_en;
  assign epc       = t.exc_pc & ~64'd1;
  assign wd        = t.csr_wr_data;
  assign mstatus   = {51'd0, mpp, 2'd0, spp, mpie, 1'b0, spie, 1'b0, mie, 1'b0, sie, 1'b0};
  assign sstatus   = {55'd0, spp, 2'd0, spie, 3'd0, sie, 1'b0};
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = idle ? (commit ? FLUSH : IDLE) : state == FLUSH ? REDIR : t.redirect_ack ? IDLE : REDIR;
    t.busy           = !idle;
    t.flush_all      = state == FLUSH;
    t.redirect_valid = state == REDIR;
    t.redirect_pc    = rpc;
    t.priv           = priv;
  end
  // CSR writes come first so a same-edge trap or xret overrides them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      priv <= 2'b11;
      {mepc, mcause, mtval, sepc, scause, stval, rpc} <= '0;
      {mie, mpie, sie, spie, spp} <= '0;
      mpp <= 2'b00;
    end else begin
      if (wr)
        case (t.csr_wr_addr)
          12'h341: mepc   <= wd & ~64'd1;
          12'h342: mcause <= wd;
          12'h343: mtval  <= wd;
          12'h141: sepc   <= wd & ~64'd1;
          12'h142: scause <= wd;
          12'h143: stval  <= wd;
          12'h300: if (!commit) begin
            sie  <= wd[1];
            mie  <= wd[3];
            spie <= wd[5];
            mpie <= wd[7];
            spp  <= wd[8];
            mpp  <= wd[12:11] == 2'b10 ? 2'b00 : wd[12:11];
          end
          12'h100: if (!commit) begin
            sie  <= wd[1];
            spie <= wd[5];
            spp  <= wd[8];
          end
          default: ;
        endcase
      if (take_exc) begin
        rpc <= (to_s ? t.stvec : t.mtvec) & TMASK;
        if (to_s) begin
          sepc   <= epc;
          scause <= t.exc_cause;
          stval  <= t.exc_val;
          spie   <= sie;
          sie    <= 1'b0;
          spp    <= priv[0];
          priv   <= 2'b01;
        end else begin
          mepc   <= epc;
          mcause <= t.exc_cause;
          mtval  <= t.exc_val;
          mpie   <= mie;
          mie    <= 1'b0;
          mpp    <= priv;
          priv   <= 2'b11;
        end
      end
      if (take_mret) begin
        mie  <= mpie;
        mpie <= 1'b1;
        priv <= mpp;
        mpp  <= 2'b00;
        rpc  <= mepc;
      end
      if (take_sret) begin
        sie  <= spie;
        spie <= 1'b1;
        priv <= {1'b0, spp};
        spp  <= 1'b0;
        rpc  <= sepc;
      end
    end
  end
  always_comb begin
    t.csr_rd_data = '0;
    case (t.csr_rd_addr)
      12'h341: t.csr_rd_data = mepc;
      12'h342: t.csr_rd_data = mcause;
      12'h343: t.csr_rd_data = mtval;
      12'h141: t.csr_rd_data = sepc;
      12'h142: t.csr_rd_data = scause;
      12'h143: t.csr_rd_data = stval;
      12'h300: t.csr_rd_data = mstatus;
      12'h100: t.csr_rd_data = sstatus;
      default: t.csr_rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: CSR vector table plus trap/xret sequences, redirect targets checked through a scoreboard
`timescale 1ns/1ps
module tb_trap_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] sb[$];
  typedef struct {
    logic [11:0] wa;
    logic [63:0] wd;
    logic [11:0] ra;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[13];
  trap_ctrl_if b();
  trap_ctrl_if b0();
  always #5 clk = ~clk;
  // second instance has delegation disabled and sees the same stimulus
  assign b0.exc = b.exc;
  assign b0.exc_cause = b.exc_cause;
  assign b0.exc_val = b.exc_val;
  assign b0.exc_pc = b.exc_pc;
  assign b0.mret = b.mret;
  assign b0.sret = b.sret;
  assign b0.mtvec = b.mtvec;
  assign b0.stvec = b.stvec;
  assign b0.medeleg = b.medeleg;
  assign b0.csr_wr_en = b.csr_wr_en;
  assign b0.csr_wr_addr = b.csr_wr_addr;
  assign b0.csr_wr_data = b.csr_wr_data;
  assign b0.csr_rd_addr = b.csr_rd_addr;
  assign b0.redirect_ack = b.redirect_ack;
  trap_ctrl #(.DELEG_EN(1'b1), .TVEC_ALIGN(2)) dut (.clk(clk), .rst_n(rst_n), .t(b.slave));
  trap_ctrl #(.DELEG_EN(1'b0), .TVEC_ALIGN(2)) dut0 (.clk(clk), .rst_n(rst_n), .t(b0.slave));
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic rdchk(input string nm, input logic [11:0] a, input logic [63:0] e);
    @(negedge clk);
    b.csr_rd_addr = a;
    #1 chk(nm, b.csr_rd_data, e);
  endtask
  task automatic rdchk0(input string nm, input logic [11:0] a, input logic [63:0] e);
    @(negedge clk);
    b.csr_rd_addr = a;
    #1 chk(nm, b0.csr_rd_data, e);
  endtask
  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    @(negedge clk);
    b.csr_wr_en = 1'b1;
    b.csr_wr_addr = a;
    b.csr_wr_data = d;
    @(negedge clk);
    b.csr_wr_en = 1'b0;
  endtask
  // caller has set up the commit-cycle inputs; the next posedge is the commit edge
  task automatic xact(input logic [63:0] exp, input logic [63:0] exp0, input int ack_wait, input bit noise);
    int cnt;
    logic [63:0] e;
    sb.push_back(exp);
    @(negedge clk);
    b.exc = noise;
    b.mret = noise;
    b.sret = 1'b0;
    b.csr_wr_en = noise;
    b.csr_wr_addr = 12'h342;
    b.csr_wr_data = 64'h3f;
    chk("flush_cycle1", b.flush_all, 1);
    chk("busy_cycle1", b.busy, 1);
    chk("rv_cycle1", b.redirect_valid, 0);
    @(negedge clk);
    chk("flush_cycle2", b.flush_all, 0);
    cnt = 0;
    while (!b.redirect_valid && cnt < 4) begin
      @(negedge clk);
      cnt++;
    end
    chk("redirect_latency", 64'(cnt), 0);
    e = sb.pop_front();
    chk("dut0_redirect_pc", b0.redirect_pc, exp0);
    for (int i = 0; i <= ack_wait; i++) begin
      chk("redirect_valid_hold", b.redirect_valid, 1);
      chk("redirect_pc", b.redirect_pc, e);
      if (i < ack_wait) @(negedge clk);
    end
    b.redirect_ack = 1'b1;
    b.exc = 1'b0;
    b.mret = 1'b0;
    b.csr_wr_en = 1'b0;
    @(negedge clk);
    b.redirect_ack = 1'b0;
    chk("idle_after_ack", b.busy, 0);
    chk("rv_after_ack", b.redirect_valid, 0);
  endtask
  initial begin
    b.exc = 0; b.exc_cause = 0; b.exc_val = 0; b.exc_pc = 0;
    b.mret = 0; b.sret = 0; b.mtvec = 64'h80001003; b.stvec = 64'h2000; b.medeleg = 0;
    b.csr_wr_en = 0; b.csr_wr_addr = 0; b.csr_wr_data = 0; b.csr_rd_addr = 0; b.redirect_ack = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_priv", b.priv, 2'b11);
    chk("reset_busy", b.busy, 0);
    chk("reset_flush", b.flush_all, 0);
    chk("reset_rv", b.redirect_valid, 0);
    chk("reset_rpc", b.redirect_pc, 0);
    rdchk("reset_mstatus", 12'h300, 0);
    rdchk("reset_mepc", 12'h341, 0);
    tbl[0]  = '{12'h341, 64'h1235, 12'h341, 64'h1234};
    tbl[1]  = '{12'h342, 64'h7, 12'h342, 64'h7};
    tbl[2]  = '{12'h343, 64'hdead, 12'h343, 64'hdead};
    tbl[3]  = '{12'h141, 64'hffff, 12'h141, 64'hfffe};
    tbl[4]  = '{12'h142, 64'hc, 12'h142, 64'hc};
    tbl[5]  = '{12'h143, 64'hbeef, 12'h143, 64'hbeef};
    tbl[6]  = '{12'h300, '1, 12'h300, 64'h19aa};
    tbl[7]  = '{12'h300, '1, 12'h100, 64'h122};
    tbl[8]  = '{12'h300, 64'h1000, 12'h300, 64'h0};
    tbl[9]  = '{12'h300, 64'h0800, 12'h300, 64'h800};
    tbl[10] = '{12'h100, '1, 12'h300, 64'h922};
    tbl[11] = '{12'h100, 64'h0, 12'h100, 64'h0};
    tbl[12] = '{12'h305, '1, 12'h305, 64'h0};
    for (int i = 0; i < 13; i++) begin
      wr(tbl[i].wa, tbl[i].wd);
      rdchk($sformatf("csr_tbl%0d", i), tbl[i].ra, tbl[i].exp);
    end
    @(negedge clk);
    b.csr_wr_en = 1'b1; b.csr_wr_addr = 12'h343; b.csr_wr_data = 64'h1; b.csr_rd_addr = 12'h343;
    #1 chk("rd_not_bypassed", b.csr_rd_data, 64'hdead);
    @(negedge clk);
    b.csr_wr_en = 1'b0;
    // M trap with a same-cycle mret and noise during FLUSH/REDIR
    wr(12'h300, 64'h8);
    b.exc = 1; b.exc_cause = 2; b.exc_val = 64'hdeadbeef; b.exc_pc = 64'h80000105; b.mret = 1;
    xact(64'h80001000, 64'h80001000, 0, 1);
    rdchk("m_trap_mepc", 12'h341, 64'h80000104);
    rdchk("m_trap_mcause", 12'h342, 2);
    rdchk("m_trap_mtval", 12'h343, 64'hdeadbeef);
    rdchk("m_trap_mstatus", 12'h300, 64'h1880);
    chk("m_trap_priv", b.priv, 2'b11);
    wr(12'h300, 64'h880);
    b.mret = 1;
    xact(64'h80000104, 64'h80000104, 5, 0);
    chk("mret_priv", b.priv, 2'b01);
    rdchk("mret_mstatus", 12'h300, 64'h88);
    wr(12'h141, 64'h4000);
    wr(12'h100, 64'h20);
    rdchk("sstatus_write_keeps_m", 12'h300, 64'ha8);
    b.sret = 1;
    xact(64'h4000, 64'h4000, 0, 0);
    chk("sret_priv", b.priv, 2'b00);
    rdchk("sret_sstatus", 12'h100, 64'h22);
    @(negedge clk);
    b.mret = 1;
    @(negedge clk);
    b.mret = 0; b.sret = 1;
    @(negedge clk);
    b.sret = 0;
    chk("illegal_xret_busy", b.busy, 0);
    chk("illegal_xret_priv", b.priv, 2'b00);
    // delegated ecall from U with a concurrent write to mcause
    b.medeleg = 64'h100;
    b.exc = 1; b.exc_cause = 8; b.exc_val = 64'h11; b.exc_pc = 64'h3000;
    b.csr_wr_en = 1; b.csr_wr_addr = 12'h342; b.csr_wr_data = 64'h9;
    xact(64'h2000, 64'h80001000, 0, 0);
    chk("deleg_priv", b.priv, 2'b01);
    rdchk("deleg_sepc", 12'h141, 64'h3000);
    rdchk("deleg_scause", 12'h142, 8);
    rdchk("deleg_stval", 12'h143, 64'h11);
    rdchk("deleg_sstatus", 12'h100, 64'h20);
    rdchk("deleg_other_csr_write", 12'h342, 9);
    chk("nodeleg_priv", b0.priv, 2'b11);
    rdchk0("nodeleg_mcause", 12'h342, 8);
    rdchk0("nodeleg_mepc", 12'h341, 64'h3000);
    rdchk0("nodeleg_mstatus", 12'h300, 64'ha2);
    b.exc = 1; b.exc_cause = 5; b.exc_val = 0; b.exc_pc = 64'h5000;
    b.csr_wr_en = 1; b.csr_wr_addr = 12'h342; b.csr_wr_data = 64'h7;
    xact(64'h80001000, 64'h80001000, 0, 0);
    chk("trap_over_write_priv", b.priv, 2'b11);
    rdchk("trap_over_write_mcause", 12'h342, 5);
    rdchk("trap_over_write_mepc", 12'h341, 64'h5000);
    rdchk("trap_from_s_mstatus", 12'h300, 64'h8a0);
    // reset while waiting in REDIR
    @(negedge clk);
    b.exc = 1; b.exc_cause = 2;
    @(negedge clk);
    b.exc = 0;
    @(negedge clk);
    chk("rv_before_reset", b.redirect_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_reset_priv", b.priv, 2'b11);
    chk("mid_reset_busy", b.busy, 0);
    chk("mid_reset_rv", b.redirect_valid, 0);
    chk("mid_reset_flush", b.flush_all, 0);
    chk("mid_reset_rpc", b.redirect_pc, 0);
    @(negedge clk);
    chk("no_redirect_after_reset", b.redirect_valid, 0);
    rdchk("mid_reset_mepc", 12'h341, 0);
    rdchk("mid_reset_mstatus", 12'h300, 0);
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Consumer side of the exception path. Takes the prioritised exc/exc_cause/exc_val from the exception unit, plus mret/sret from the MEM stage, and performs trap entry and trap return. It owns the privilege register, the trap CSRs (mepc/mcause/mtval, sepc/scause/stval) and the mstatus trap bits. It sequences the pipeline flush and the PC redirect to mtvec/stvec or to the return address.

Parameters:
DELEG_EN, 1, enables delegation of exceptions to S-mode via medeleg; 0 = all traps taken in M.
TVEC_ALIGN, 2, number of low bits cleared from mtvec/stvec to form the handler address (direct mode only).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
exc  in  1  exception pending at commit point
exc_cause  in  64  cause code, low 6 bits significant
exc_val  in  64  trap value
exc_pc  in  64  PC of the faulting instruction
mret  in  1  MRET at commit point
sret  in  1  SRET at commit point
mtvec  in  64  M trap vector CSR
stvec  in  64  S trap vector CSR
medeleg  in  64  exception delegation mask
csr_wr_en  in  1  software CSR write strobe
csr_wr_addr  in  12  CSR address
csr_wr_data  in  64  CSR write data
csr_rd_addr  in  12  CSR read address
csr_rd_data  out  64  combinational read of owned CSRs, 0 if not owned
priv  out  2  current privilege (00 U, 01 S, 11 M)
busy  out  1  state != IDLE; upstream stalls all stages
flush_all  out  1  flush PD/ID/EX/MEM
redirect_valid  out  1  redirect_pc valid
redirect_pc  out  64  fetch redirect target
redirect_ack  in  1  fetch accepted redirect

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; priv=11; all trap CSRs 0; MIE/MPIE/SIE/SPIE/SPP=0, MPP=00. Outputs: busy, flush_all, redirect_valid all 0; redirect_pc=0. Reset mid-sequence aborts to IDLE with no redirect.
- FSM states: IDLE, FLUSH, REDIR.
- IDLE, exc=1, trap commit on the same edge:
  - Target is S if DELEG_EN && priv!=11 && medeleg[exc_cause[5:0]]; otherwise target is M.
  - Writes for target M: mepc={exc_pc[63:1],0}, mcause=exc_cause, mtval=exc_val, MPIE<=MIE, MIE<=0, MPP<=priv, priv<=11.
  - Writes for target S: sepc, scause, stval written the same way; SPIE<=SIE, SIE<=0, SPP<=priv[0], priv<=01.
  - redirect_pc <= target tvec with low TVEC_ALIGN bits cleared.
  - Next state: FLUSH.
- IDLE, exc=0, mret=1, priv==11: MIE<=MPIE, MPIE<=1, priv<=MPP, MPP<=00, redirect_pc<=mepc; next state FLUSH.
- IDLE, exc=0, sret=1, priv!=00: SIE<=SPIE, SPIE<=1, priv<={0,SPP}, SPP<=0, redirect_pc<=sepc; next state FLUSH.
- Illegal xret (mret below M, sret in U) is flagged upstream as exc. If it arrives here with exc=0, it is ignored.
- Priority: exc > mret > sret. A trap commit or xret overrides a same-cycle csr_wr_en to the same register; the CSR write to any other register still occurs.
- FLUSH: flush_all=1 for exactly one cycle, busy=1; next state REDIR.
- REDIR: redirect_valid=1 and redirect_pc held until redirect_ack=1. On the ack edge, next state is IDLE. redirect_ack in the first REDIR cycle means REDIR lasts 1 cycle.
- Latency from commit edge: flush_all is high in cycle +1 and redirect_valid in cycle +2. Minimum 3 cycles from commit to IDLE.
- exc, mret, sret and csr_wr_en are ignored whenever state != IDLE.
- CSR map, read and write:
  - 0x341 mepc, 0x342 mcause, 0x343 mtval.
  - 0x141 sepc, 0x142 scause, 0x143 stval.
  - 0x300 mstatus: only SIE[1], MIE[3], SPIE[5], MPIE[7], SPP[8], MPP[12:11] are stored; other bits read 0.
  - 0x100 sstatus: SIE, SPIE, SPP view; writes affect only those bits.
  - Writes to mepc/sepc force bit 0 to 0.
  - A write of MPP=10 stores 00.
  - csr_rd_data reflects register state, not same-cycle write data.

Test Plan:
- M-mode exc, cause=2, val=0xdeadbeef, exc_pc=0x80000105, mtvec=0x80001003 -> mepc=0x80000104, mcause=2, mtval=0xdeadbeef, flush_all high 1 cycle, redirect_pc=0x80001000, priv stays 11, MPP=11.
- U-mode ecall with medeleg[8]=1, cause=8, stvec=0x2000 -> sepc/scause set, SPP=0, priv=01, redirect_pc=0x2000. Repeat with DELEG_EN=0 -> M trap, MPP=00.
- mret with MPP=01, MPIE=1 -> priv=01, MIE=1, MPP=00, redirect_pc=mepc. sret with SPP=0 -> priv=00, redirect_pc=sepc.
- exc and mret in the same cycle -> only trap entry, mepc updated, MPIE<=MIE. exc pulse during FLUSH/REDIR -> no state change.
- redirect_ack withheld 5 cycles -> redirect_valid stays 1 with pc stable for 5 cycles, then IDLE the cycle after ack. Reset asserted in REDIR -> priv=11, busy=0 next cycle.
- csr_wr_en to 0x342 with data 7, concurrent with exc cause 5 -> mcause=5. csr write 0x300 of 0xffffffffffffffff -> reads back 0x19aa.
